// File: rtl/gate_pkg.sv
// Shared opcode and state definitions for the gate evaluation unit and its arbiter.
package gate_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_NAND    = 3'd2;
  localparam logic [2:0] OP_NOR     = 3'd3;
  localparam logic [2:0] OP_XOR     = 3'd4;
  localparam logic [2:0] OP_XNOR    = 3'd5;
  localparam logic [2:0] OP_NOT     = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

endpackage

// File: rtl/gate_eval.sv
// Purely combinational bitwise gate: (op, a, b) -> (y, err). NOT uses a only.
module gate_eval
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one gate_eval between NUM_REQ requesters,
// with a single registered, ID-tagged response channel.
//
//   state   | meaning
//   --------+-----------------------------------------
//   ST_IDLE | output register empty, rsp_valid low
//   ST_FULL | output register holds an unconsumed result
module gate_unit_arbiter
  import gate_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic               can_accept;
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0] valid_rot;
  logic [ID_W:0]      cand;
  logic [ID_W:0]      ptr_inc;
  logic               grant_any;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant_vec;

  logic [2:0]         sel_op;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [WIDTH-1:0]   eval_y;
  logic               eval_err;

  // rst_n gates acceptance so req_ready stays low throughout reset.
  assign can_accept = rst_n & ((state_q == ST_IDLE) | (rsp_valid & rsp_ready));

  // Rotate so rr_ptr sits at bit 0, take the first set bit, then map back.
  always_comb begin
    valid_dbl = {req_valid, req_valid} >> rr_ptr_q;
    valid_rot = valid_dbl[NUM_REQ-1:0];
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (can_accept) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (valid_rot[k]) begin
          grant_any = 1'b1;
          cand      = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
          if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
          end
          grant_idx = cand[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (grant_idx == ID_W'(i))) begin
        grant_vec[i] = 1'b1;
        sel_op       = req_op[3*i +: 3];
        sel_a        = req_a[WIDTH*i +: WIDTH];
        sel_b        = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  assign req_ready = grant_vec;

  gate_eval #(
    .WIDTH(WIDTH)
  ) u_gate_eval (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (eval_y),
    .err(eval_err)
  );

  always_comb begin
    ptr_inc = {1'b0, grant_idx} + 1'b1;
    if (ptr_inc == (ID_W+1)'(NUM_REQ)) begin
      ptr_inc = '0;
    end
    rr_ptr_d = grant_any ? ptr_inc[ID_W-1:0] : rr_ptr_q;
  end

  always_comb begin
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (grant_any) begin
      rsp_id_d   = grant_idx;
      rsp_data_d = eval_y;
      rsp_err_d  = eval_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // A drain with a same-cycle grant keeps the register full (back-to-back).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_any) state_d = ST_FULL;
      ST_FULL: if (rsp_ready) state_d = grant_any ? ST_FULL : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (state_q == ST_FULL);
    rsp_id    = rsp_id_q;
    rsp_data  = rsp_data_q;
    rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter: opcode vector table plus hand-written
// sequences for fairness, backpressure and reset while full.
module tb_gate_unit_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_err;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       err;
  } vec_t;

  vec_t vecs [8];

  gate_unit_arbiter #(
    .NUM_REQ(NUM_REQ),
    .WIDTH  (WIDTH),
    .ID_W   (ID_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3]       = op;
    req_a[WIDTH*i +: WIDTH] = a;
    req_b[WIDTH*i +: WIDTH] = b;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    vecs[0] = '{3'd0, 8'hA5, 8'h0F, 8'h05, 1'b0};
    vecs[1] = '{3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b0};
    vecs[2] = '{3'd2, 8'hA5, 8'h0F, 8'hFA, 1'b0};
    vecs[3] = '{3'd3, 8'hA5, 8'h0F, 8'h50, 1'b0};
    vecs[4] = '{3'd4, 8'hA5, 8'h0F, 8'hAA, 1'b0};
    vecs[5] = '{3'd5, 8'hA5, 8'h0F, 8'h55, 1'b0};
    vecs[6] = '{3'd6, 8'hA5, 8'h0F, 8'h5A, 1'b0};
    vecs[7] = '{3'd7, 8'hA5, 8'h0F, 8'h00, 1'b1};

    // Reset held with every requester valid
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    #2;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data",  32'(rsp_data),  32'h0);
    chk("reset_rsp_err",   32'(rsp_err),   32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset_held_ready", 32'(req_ready), 32'h0);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    @(posedge clk); #1;

    // Single AND on req0
    set_req(0, 3'd0, 8'hF0, 8'h3C);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid), 32'h1);
    chk("single_id",    32'(rsp_id),    32'h0);
    chk("single_data",  32'(rsp_data),  32'h30);
    chk("single_err",   32'(rsp_err),   32'h0);
    @(posedge clk); #1;

    // Opcode sweep on req1
    for (int v = 0; v < 8; v++) begin
      set_req(1, vecs[v].op, vecs[v].a, vecs[v].b);
      req_valid = 4'b0010;
      @(negedge clk);
      chk("sweep_ready", 32'(req_ready), 32'h2);
      @(posedge clk); #1;
      req_valid = 4'b0000;
      @(negedge clk);
      chk("sweep_valid", 32'(rsp_valid), 32'h1);
      chk("sweep_id",    32'(rsp_id),    32'h1);
      chk("sweep_data",  32'(rsp_data),  32'(vecs[v].y));
      chk("sweep_err",   32'(rsp_err),   32'(vecs[v].err));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("sweep_drained", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;

    // Return the pointer to 0, then all requesters valid
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'd1, 8'(i), 8'h80);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
      if (c > 0) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rr_rsp_id",    32'(rsp_id),    32'((c - 1) % 4));
        chk("rr_rsp_data",  32'(rsp_data),  32'(8'h80 + ((c - 1) % 4)));
      end
      @(posedge clk);
    end
    #1;

    // Backpressure with req1's result held
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_id",    32'(rsp_id),    32'h1);
      chk("bp_data",  32'(rsp_data),  32'h81);
      chk("bp_err",   32'(rsp_err),   32'h0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_id",   32'(rsp_id),   32'h2);
    chk("bp_after_data", 32'(rsp_data), 32'h82);

    // Reset while FULL: async clear, then grant restarts from req0
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_full_valid", 32'(rsp_valid), 32'h0);
    chk("rst_full_ready", 32'(req_ready), 32'h0);
    chk("rst_full_data",  32'(rsp_data),  32'h0);
    chk("rst_full_id",    32'(rsp_id),    32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("post_rst_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_id",    32'(rsp_id),    32'h0);
    chk("post_rst_data",  32'(rsp_data),  32'h80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
